// File: rtl/corr_result_tx.sv
// Snapshots the correlator status and six accumulators on a request and streams
// them as a framed, checksummed 55-byte packet over a valid/ready byte interface.
module corr_result_tx #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter logic [7:0] TRAILER = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] sr_in,
    input  logic [63:0] sum_x_2,
    input  logic [63:0] sum_y_2,
    input  logic [63:0] sum_xy,
    input  logic [63:0] sum_xy90,
    input  logic [63:0] sum_y90_2,
    input  logic [63:0] sum_y_y90,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        req_drop
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_CHK  = 2'd2,
        S_TRL  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [7:0]   csum_q, csum_d;
    logic [415:0] snap_q, snap_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic         tx_valid_q, tx_valid_d;
    logic         busy_q, busy_d;
    logic         frame_done_q, frame_done_d;
    logic         req_drop_q, req_drop_d;
    logic         accept_s;

    assign accept_s = tx_valid_q & tx_ready;

    // State, counters and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 6'd0;
            csum_q       <= 8'h00;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            req_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            csum_q       <= csum_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            req_drop_q   <= req_drop_d;
        end
    end

    // Snapshot shifter; its contents are irrelevant outside a frame
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    // Next-state: capture on request, then walk the frame one accepted byte at a time
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        snap_d     = snap_q;
        req_drop_d = req_drop_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    snap_d     = {sr_in, sum_x_2, sum_y_2, sum_xy, sum_xy90, sum_y90_2, sum_y_y90};
                    cnt_d      = 6'd0;
                    csum_d     = 8'h00;
                    req_drop_d = 1'b0;
                    state_d    = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (!accept_s) begin
                    state_d = S_SEND;
                end else if (cnt_q == 6'd0) begin
                    cnt_d = 6'd1;
                end else begin
                    // Payload byte leaves from the top of the snapshot, then shift up
                    csum_d  = csum_q + snap_q[415:408];
                    snap_d  = {snap_q[407:0], 8'h00};
                    cnt_d   = cnt_q + 6'd1;
                    state_d = (cnt_q == 6'd52) ? S_CHK : S_SEND;
                end
            end
            S_CHK: begin
                if (accept_s) begin
                    state_d = S_TRL;
                end else begin
                    state_d = S_CHK;
                end
            end
            S_TRL: begin
                if (accept_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TRL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (req && (state_q != S_IDLE)) begin
            req_drop_d = 1'b1;
        end else begin
            req_drop_d = req_drop_d;
        end
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        tx_data_d    = 8'h00;
        tx_valid_d   = 1'b0;
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_q == S_TRL) && accept_s;
        case (state_d)
            S_IDLE: begin
                tx_data_d  = 8'h00;
                tx_valid_d = 1'b0;
            end
            S_SEND: begin
                tx_valid_d = 1'b1;
                tx_data_d  = (cnt_d == 6'd0) ? HEADER : snap_d[415:408];
            end
            S_CHK: begin
                tx_valid_d = 1'b1;
                tx_data_d  = csum_d;
            end
            S_TRL: begin
                tx_valid_d = 1'b1;
                tx_data_d  = TRAILER;
            end
            default: begin
                tx_data_d  = 8'h00;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign req_drop   = req_drop_q;

endmodule

// File: tb/tb_corr_result_tx.sv
// Directed bench for corr_result_tx: expected frame bytes are queued at request
// time and a negedge monitor pops and compares each accepted byte.
module tb_corr_result_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] sr_in;
    logic [63:0] sum_x_2, sum_y_2, sum_xy, sum_xy90, sum_y90_2, sum_y_y90;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy, frame_done, req_drop;

    logic [7:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          n_holds  = 0;
    logic        rdy_mode = 1'b0;

    corr_result_tx dut (
        .clk(clk), .rst(rst), .req(req), .sr_in(sr_in),
        .sum_x_2(sum_x_2), .sum_y_2(sum_y_2), .sum_xy(sum_xy),
        .sum_xy90(sum_xy90), .sum_y90_2(sum_y90_2), .sum_y_y90(sum_y_y90),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done), .req_drop(req_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [31:0] sr, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic [63:0] d, input logic [63:0] e,
                              input logic [63:0] f, input logic [7:0] csum);
        logic [63:0] w [6];
        w = '{a, b, c, d, e, f};
        exp_q.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) exp_q.push_back(sr[8*i +: 8]);
        for (int k = 0; k < 6; k++)
            for (int i = 7; i >= 0; i--) exp_q.push_back(w[k][8*i +: 8]);
        exp_q.push_back(csum);
        exp_q.push_back(8'h5A);
    endtask

    task automatic set_inputs(input logic [31:0] sr, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic [63:0] d, input logic [63:0] e,
                              input logic [63:0] f);
        sr_in = sr; sum_x_2 = a; sum_y_2 = b; sum_xy = c; sum_xy90 = d; sum_y90_2 = e; sum_y_y90 = f;
    endtask

    task automatic do_req();
        @(posedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk("frame_done_seen", seen, 1'b1);
        chk("busy_after_frame", busy, 1'b0);
        chk("valid_after_frame", tx_valid, 1'b0);
        chk("bytes_left_in_queue", exp_q.size(), 0);
    endtask

    // tx_ready driver: constant high, or the 1-0-0-1 backpressure pattern
    initial begin
        int phase;
        phase = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode) begin
                tx_ready = (phase == 0) || (phase == 3);
                phase = (phase + 1) % 4;
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    // Monitor: accepted bytes against the scoreboard, stability under stall
    initial begin
        logic       stall_prev;
        logic [7:0] prev_data;
        logic [7:0] e;
        stall_prev = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    n_holds++;
                    chk("hold_valid", tx_valid, 1'b1);
                    chk("hold_data", tx_data, prev_data);
                end
                if (tx_valid) begin
                    chk("busy_while_valid", busy, 1'b1);
                    if (tx_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_byte", tx_data, 8'hxx);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_byte", tx_data, e);
                        end
                    end
                end
                stall_prev = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    initial begin
        int fd_at, vcount;
        rst = 1'b0; req = 1'b0;
        set_inputs(32'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_req_drop", req_drop, 1'b0);
        @(posedge clk); #1 rst = 1'b1;

        // Single frame, ready held high: latency, no bubbles, frame_done in cycle 56
        set_inputs(32'h00000001, 64'h0102030405060708, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        push_frame(32'h00000001, 64'h0102030405060708, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 8'h25);
        do_req();
        fd_at = 0; vcount = 0;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (tx_valid) vcount++;
            if (frame_done && fd_at == 0) fd_at = n;
            if (n == 1) chk("first_valid_latency", tx_valid, 1'b1);
        end
        chk("frame_done_cycle", fd_at, 56);
        chk("valid_cycles", vcount, 55);
        chk("t1_queue_empty", exp_q.size(), 0);
        chk("t1_busy_idle", busy, 1'b0);

        // Backpressure 1-0-0-1
        rdy_mode = 1'b1;
        push_frame(32'h00000001, 64'h0102030405060708, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 8'h25);
        do_req();
        wait_done();
        rdy_mode = 1'b0;
        chk("stalls_observed", (n_holds > 0), 1'b1);

        // Snapshot isolation: inputs all ones right after the capture edge
        set_inputs(32'h00000003, 64'h0, 64'h10, 64'h0, 64'h0, 64'h0, 64'h2000000000000000);
        push_frame(32'h00000003, 64'h0, 64'h10, 64'h0, 64'h0, 64'h0, 64'h2000000000000000, 8'h33);
        do_req();
        set_inputs(32'hFFFFFFFF, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}});
        wait_done();

        // Collision mid-frame, then a req in the frame_done cycle (checksum wrap frame)
        set_inputs(32'h00000001, 64'h0102030405060708, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        push_frame(32'h00000001, 64'h0102030405060708, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 8'h25);
        do_req();
        set_inputs(32'hFFFFFFFF, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}});
        repeat (9) @(posedge clk);
        #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("req_drop_set", req_drop, 1'b1);
        wait_done();
        chk("req_drop_sticky", req_drop, 1'b1);
        req = 1'b1;
        push_frame(32'hFFFFFFFF, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, 8'hCC);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("req_drop_cleared", req_drop, 1'b0);
        chk("busy_after_accept", busy, 1'b1);
        wait_done();

        // Reset mid-frame aborts, then a fresh frame is complete
        set_inputs(32'h00000001, 64'h0102030405060708, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        push_frame(32'h00000001, 64'h0102030405060708, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 8'h25);
        do_req();
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_tx_valid", tx_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_frame_done", frame_done, 1'b0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        push_frame(32'h00000001, 64'h0102030405060708, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 8'h25);
        do_req();
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
